// File: rtl/fetch_stage.sv
// Instruction fetch front end: sequential bundle requests from a PC,
// credit-limited in-order bundle buffer, redirect flush with response drop.
module fetch_stage #(
  parameter int ADDR_WIDTH         = 16,
  parameter int RESET_PC           = 0,
  parameter int FIFO_DEPTH         = 4,
  parameter int SUPER_SCALAR_WIDTH = 2,
  parameter int WORD_WIDTH         = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  output logic                  imem_valid_out,
  input  logic                  imem_ready_in,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic                  imem_resp_valid_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][WORD_WIDTH-1:0]
                                imem_resp_data_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  input  logic                  decode_ready_in,
  output logic                  decode_valid_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][WORD_WIDTH-1:0]
                                decode_data_out,
  output logic [ADDR_WIDTH-1:0] decode_pc_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(SUPER_SCALAR_WIDTH);
  localparam logic [CW:0]           DEPTH  = (CW+1)'(FIFO_DEPTH);

  typedef logic [SUPER_SCALAR_WIDTH-1:0][WORD_WIDTH-1:0] bundle_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rpc_q, rpc_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [PW-1:0]         wr_q, wr_d;
  bundle_t               data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_q  [FIFO_DEPTH];

  logic [CW:0] used;
  logic        issue;
  logic        resp;
  logic        push;
  logic        pop;

  assign used  = {1'b0, cnt_q} + {1'b0, out_q};
  assign resp  = imem_resp_valid_in;

  assign imem_valid_out   = rst_in && !redirect_valid_in
                            && (used < DEPTH);
  assign imem_addr_out    = pc_q;
  assign issue            = imem_valid_out && imem_ready_in;

  assign decode_valid_out = rst_in && (cnt_q != '0);
  assign decode_data_out  = data_q[rd_q];
  assign decode_pc_out    = tag_q[rd_q];

  // rpc_q is the PC of the next response that will be kept
  assign push = resp && (drop_q == '0) && !redirect_valid_in;
  assign pop  = decode_valid_out && decode_ready_in
                && !redirect_valid_in;

  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    drop_d = drop_q;
    out_d  = out_q + CW'(issue) - CW'(resp);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    rd_d   = rd_q + PW'(pop);
    wr_d   = wr_q + PW'(push);
    if (redirect_valid_in) begin
      pc_d  = redirect_pc_in;
      rpc_d = redirect_pc_in;
      cnt_d = '0;
      rd_d  = wr_q;
    end else begin
      if (issue) pc_d = pc_q + STEP;
      if (push)  rpc_d = rpc_q + STEP;
    end
    priority case (1'b1)
      redirect_valid_in:
        drop_d = out_q - CW'(resp);
      (resp && (drop_q != '0)):
        drop_d = drop_q - CW'(1);
      default:
        drop_d = drop_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pc_q   <= RST_PC;
      rpc_q  <= RST_PC;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && push) begin
      data_q[wr_q] <= imem_resp_data_in;
      tag_q[wr_q]  <= rpc_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && push && !pop)
      assert (cnt_q < CW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage with a latency-modelled
// instruction memory and an epoch-based model of redirect flushing.
module tb_fetch_stage;

  localparam int AW = 16;
  localparam int W  = 2;
  localparam int D  = 4;
  localparam int WW = 32;
  localparam logic [AW-1:0] RST_PC = '0;

  typedef logic [W-1:0][WW-1:0] bundle_t;
  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
    int            due;
  } req_t;
  typedef struct {
    logic [AW-1:0] pc;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_in = 1'b0;
  logic          imem_valid_out;
  logic          imem_ready_in = 1'b0;
  logic [AW-1:0] imem_addr_out;
  logic          imem_resp_valid_in = 1'b0;
  bundle_t       imem_resp_data_in = '0;
  logic          redirect_valid_in = 1'b0;
  logic [AW-1:0] redirect_pc_in = '0;
  logic          decode_ready_in = 1'b0;
  logic          decode_valid_out;
  bundle_t       decode_data_out;
  logic [AW-1:0] decode_pc_out;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_WIDTH(AW), .RESET_PC(0), .FIFO_DEPTH(D),
    .SUPER_SCALAR_WIDTH(W), .WORD_WIDTH(WW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .imem_valid_out(imem_valid_out),
    .imem_ready_in(imem_ready_in),
    .imem_addr_out(imem_addr_out),
    .imem_resp_valid_in(imem_resp_valid_in),
    .imem_resp_data_in(imem_resp_data_in),
    .redirect_valid_in(redirect_valid_in),
    .redirect_pc_in(redirect_pc_in),
    .decode_ready_in(decode_ready_in),
    .decode_valid_out(decode_valid_out),
    .decode_data_out(decode_data_out),
    .decode_pc_out(decode_pc_out)
  );

  req_t mem_q[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   epoch = 0;
  logic [AW-1:0] next_pc = RST_PC;

  int   lat_min = 1, lat_max = 1;
  int   p_ir = 100, p_dr = 100, p_rd = 0;
  logic force_rd = 1'b0;
  logic force_rst = 1'b1;
  logic [AW-1:0] force_pc = '0;
  logic prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  function automatic bundle_t mem_bundle(logic [AW-1:0] a);
    bundle_t b;
    logic [AW-1:0] w;
    for (int i = 0; i < W; i++) begin
      w = a + AW'(i);
      b[i] = {w ^ 16'hA5C3, w + 16'h1357};
    end
    return b;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    req_t r;
    logic discard_now;
    logic exp_iv;
    @(negedge clk);
    cyc++;
    discard_now = 1'b0;
    rst_in = !force_rst;
    redirect_valid_in = rst_in &&
      (force_rd || ($urandom_range(99) < p_rd));
    redirect_pc_in = force_rd ? force_pc : AW'($urandom);
    imem_ready_in = ($urandom_range(99) < p_ir);
    decode_ready_in = ($urandom_range(99) < p_dr);
    imem_resp_valid_in = 1'b0;
    imem_resp_data_in = {$urandom, $urandom};
    if (!rst_in) begin
      mem_q.delete();
      exp_q.delete();
      next_pc = RST_PC;
      epoch++;
      prev_stall = 1'b0;
    end else begin
      if (redirect_valid_in) begin
        epoch++;
        exp_q.delete();
        next_pc = redirect_pc_in;
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        r = mem_q.pop_front();
        imem_resp_valid_in = 1'b1;
        imem_resp_data_in = mem_bundle(r.addr);
        if (r.epoch == epoch) exp_q.push_back('{r.addr, cyc});
        else discard_now = 1'b1;
      end
    end
    #1;
    // Credits: in-flight (incl. a response being dropped now) plus buffered
    exp_iv = rst_in && !redirect_valid_in &&
      (mem_q.size() + exp_q.size() + int'(discard_now) < D);
    check("imem_valid", 64'(imem_valid_out), 64'(exp_iv));
    if (prev_stall && rst_in && !redirect_valid_in)
      check("imem_addr_hold", 64'(imem_addr_out), 64'(prev_addr));
    if (imem_valid_out && imem_ready_in) begin
      check("imem_addr", 64'(imem_addr_out), 64'(next_pc));
      mem_q.push_back('{next_pc, epoch,
                        cyc + int'($urandom_range(lat_max, lat_min))});
      next_pc = next_pc + AW'(W);
    end
    prev_stall = imem_valid_out && !imem_ready_in;
    prev_addr = imem_addr_out;
  endtask

  always @(negedge clk) begin : monitor
    logic ev;
    #2;
    if (!rst_in) begin
      check("dec_valid_rst", 64'(decode_valid_out), 64'd0);
    end else if (!redirect_valid_in) begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
      check("dec_valid", 64'(decode_valid_out), 64'(ev));
      if (decode_valid_out && ev) begin
        check("dec_pc", 64'(decode_pc_out), 64'(exp_q[0].pc));
        check("dec_data", 64'(decode_data_out),
              64'(mem_bundle(exp_q[0].pc)));
        if (decode_ready_in) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_to(logic [AW-1:0] pc);
    force_rd = 1'b1;
    force_pc = pc;
    step();
    force_rd = 1'b0;
  endtask

  initial begin : main
    int left;
    force_rst = 1'b1;
    run(3);
    force_rst = 1'b0;

    lat_min = 1; lat_max = 1; p_ir = 100; p_dr = 100;
    run(40);

    lat_min = 3; lat_max = 3; p_dr = 0;
    run(20);
    p_dr = 100;
    run(20);

    lat_min = 1; lat_max = 4; p_ir = 50; p_dr = 70;
    run(60);

    lat_min = 3; lat_max = 3; p_ir = 100; p_dr = 0;
    run(3);
    redirect_to(16'h0100);
    p_dr = 100;
    run(20);
    redirect_to(16'hFFFE);
    run(20);

    lat_min = 1; lat_max = 5; p_ir = 70; p_dr = 60; p_rd = 10;
    run(400);
    p_rd = 0;

    lat_min = 1; lat_max = 1; p_ir = 100; p_dr = 0;
    run(12);
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    p_dr = 100;
    run(30);

    p_ir = 0; p_dr = 100;
    left = 200;
    while ((mem_q.size() > 0 || exp_q.size() > 0) && left > 0) begin
      step();
      left--;
    end
    run(2);
    check("drain_left", 64'(mem_q.size() + exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
